vga_frame_sink: RTL and testbench

//  Receiving end of the pixel-plot interface (iX/iY/iColour/iPlot) driven by the screen drawers.

---
 rtl/vga_frame_sink_if.sv | 11 +
 rtl/vga_frame_sink.sv | 168 ++++++++++++++++
 tb/tb_vga_frame_sink.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/vga_frame_sink_if.sv
// Pixel-plot bus carrying coordinates, colour and the write strobe from the
// screen drawers (master) to the frame sink (slave).
interface vga_frame_sink_if;
  logic [7:0] iX;
  logic [6:0] iY;
  logic [2:0] iColour;
  logic       iPlot;

  modport master (output iX, iY, iColour, iPlot);
  modport slave  (input  iX, iY, iColour, iPlot);
endinterface

// File: rtl/vga_frame_sink.sv
// Frame sink: stores plotted pixels in an H_RES x V_RES buffer and scans it out as VGA with 4x4
// pixel replication. Build macro FB_CLEAR_EN adds the iClear/oClearBusy buffer-clear sweep.
module vga_frame_sink #(
  parameter int H_RES       = 160,
  parameter int V_RES       = 120,
  parameter int COLOUR_BITS = 3
) (
  input  logic            iClock,
  input  logic            iReset,
  vga_frame_sink_if.slave plot,
`ifdef FB_CLEAR_EN
  input  logic            iClear,
  output logic            oClearBusy,
`endif
  output logic [7:0]      oVGA_R,
  output logic [7:0]      oVGA_G,
  output logic [7:0]      oVGA_B,
  output logic            oVGA_HS,
  output logic            oVGA_VS,
  output logic            oVGA_BLANK_N,
  output logic            oVGA_CLK,
  output logic            oFrameStart
);
  localparam int DEPTH = H_RES * V_RES;
  localparam int AW    = $clog2(DEPTH);

  // Standard 640x480 porches and sync widths around the replicated visible area
  localparam logic [9:0] H_VIS    = 10'(4 * H_RES);
  localparam logic [9:0] H_SYNC_S = 10'(4 * H_RES + 16);
  localparam logic [9:0] H_SYNC_E = 10'(4 * H_RES + 16 + 96);
  localparam logic [9:0] H_LAST   = 10'(4 * H_RES + 16 + 96 + 48 - 1);
  localparam logic [9:0] V_VIS    = 10'(4 * V_RES);
  localparam logic [9:0] V_SYNC_S = 10'(4 * V_RES + 10);
  localparam logic [9:0] V_SYNC_E = 10'(4 * V_RES + 10 + 2);
  localparam logic [9:0] V_LAST   = 10'(4 * V_RES + 10 + 2 + 33 - 1);
  localparam logic [7:0] X_LIM    = 8'(H_RES);
  localparam logic [6:0] Y_LIM    = 7'(V_RES);

  logic                   pix_en_q;
  logic [9:0]             h_q, h_d, v_q, v_d;
  logic                   frame_start_q, frame_start_d;
  logic                   s1_vis_q, s1_hs_q, s1_vs_q, s1_vis_d, s1_hs_d, s1_vs_d;
  logic [AW-1:0]          s1_addr_q, s1_addr_d;
  logic                   s2_vis_q, s2_hs_q, s2_vs_q;
  logic [COLOUR_BITS-1:0] rd_data_q;
  logic [COLOUR_BITS-1:0] fb_mem [DEPTH];
  logic                   plot_ok_s, wr_en_s;
  logic [AW-1:0]          wr_addr_s;
  logic [COLOUR_BITS-1:0] wr_data_s;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = 10'd0;
      if (v_q == V_LAST) v_d = 10'd0;
      else               v_d = v_q + 10'd1;
    end else begin
      h_d = h_q + 10'd1;
    end
    s1_vis_d = (h_q < H_VIS) && (v_q < V_VIS);
    s1_hs_d  = !((h_q >= H_SYNC_S) && (h_q < H_SYNC_E));
    s1_vs_d  = !((v_q >= V_SYNC_S) && (v_q < V_SYNC_E));
    if (s1_vis_d) s1_addr_d = AW'(v_q[9:2]) * AW'(H_RES) + AW'(h_q[9:2]);
    else          s1_addr_d = {AW{1'b0}};
    frame_start_d = pix_en_q && (h_q == 10'd0) && (v_q == V_VIS);
  end

  // Raster counters and both scan pipeline stages advance once per pixel clock
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      pix_en_q      <= 1'b0;
      h_q           <= 10'd0;
      v_q           <= 10'd0;
      frame_start_q <= 1'b0;
      s1_vis_q      <= 1'b0;
      s1_hs_q       <= 1'b1;
      s1_vs_q       <= 1'b1;
      s1_addr_q     <= {AW{1'b0}};
      s2_vis_q      <= 1'b0;
      s2_hs_q       <= 1'b1;
      s2_vs_q       <= 1'b1;
    end else begin
      pix_en_q      <= ~pix_en_q;
      frame_start_q <= frame_start_d;
      if (pix_en_q) begin
        h_q       <= h_d;
        v_q       <= v_d;
        s1_vis_q  <= s1_vis_d;
        s1_hs_q   <= s1_hs_d;
        s1_vs_q   <= s1_vs_d;
        s1_addr_q <= s1_addr_d;
        s2_vis_q  <= s1_vis_q;
        s2_hs_q   <= s1_hs_q;
        s2_vs_q   <= s1_vs_q;
      end
    end
  end

`ifdef FB_CLEAR_EN
  localparam logic [AW-1:0] A_LAST = AW'(DEPTH - 1);
  logic          clr_busy_q, clr_busy_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;

  always_comb begin
    clr_busy_d = clr_busy_q;
    clr_addr_d = clr_addr_q;
    if (clr_busy_q) begin
      if (clr_addr_q == A_LAST) begin
        clr_busy_d = 1'b0;
        clr_addr_d = {AW{1'b0}};
      end else begin
        clr_addr_d = clr_addr_q + AW'(1);
      end
    end else if (iClear) begin
      clr_busy_d = 1'b1;
      clr_addr_d = {AW{1'b0}};
    end else begin
      clr_busy_d = 1'b0;
    end
  end

  // Sweep state; a reset abandons any sweep in progress
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      clr_busy_q <= 1'b0;
      clr_addr_q <= {AW{1'b0}};
    end else begin
      clr_busy_q <= clr_busy_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  assign oClearBusy = clr_busy_q;
`endif

  always_comb begin
    plot_ok_s = plot.iPlot && (plot.iX < X_LIM) && (plot.iY < Y_LIM);
    wr_addr_s = AW'(plot.iY) * AW'(H_RES) + AW'(plot.iX);
    wr_data_s = COLOUR_BITS'(plot.iColour);
`ifdef FB_CLEAR_EN
    if (clr_busy_q) begin
      wr_en_s   = 1'b1;
      wr_addr_s = clr_addr_q;
      wr_data_s = {COLOUR_BITS{1'b0}};
    end else begin
      wr_en_s   = plot_ok_s;
    end
`else
    wr_en_s = plot_ok_s;
`endif
  end

  // Read-before-write: a same-cycle write to the scanned address shows up next frame
  always_ff @(posedge iClock) begin
    if (wr_en_s) fb_mem[wr_addr_s] <= wr_data_s;
    if (pix_en_q) rd_data_q <= fb_mem[s1_addr_q];
  end

  assign oVGA_R       = {8{rd_data_q[2] & s2_vis_q}};
  assign oVGA_G       = {8{rd_data_q[1] & s2_vis_q}};
  assign oVGA_B       = {8{rd_data_q[0] & s2_vis_q}};
  assign oVGA_HS      = s2_hs_q;
  assign oVGA_VS      = s2_vs_q;
  assign oVGA_BLANK_N = s2_vis_q;
  assign oVGA_CLK     = pix_en_q;
  assign oFrameStart  = frame_start_q;
endmodule

// File: tb/tb_vga_frame_sink.sv
// Scoreboard bench for vga_frame_sink on a reduced 16x4 buffer (64x16 visible, standard porches):
// 224 pixels/line, 61 lines/frame, so one frame is 27328 iClock cycles.
`timescale 1ns/1ps
module tb_vga_frame_sink;
  localparam int HS_FIRST  = (64 + 16) * 2 + 4;
  localparam int LINE_CLK  = 224 * 2;
  localparam int FRAME_CLK = 61 * LINE_CLK;
  localparam int VS_FIRST  = 26 * LINE_CLK + 4;
  localparam int FS_FIRST  = 16 * 224 * 2 + 2;
  // Edge (after the frame-0 start pulse) where frame 1 reads stored pixel (5,2) for the last time
  localparam int SAME_ADDR_EDGE = 2 * ((45 + 11) * 224 + 23) + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] r, g, b;
  logic hs, vs, blank_n, vga_clk, fs;
`ifdef FB_CLEAR_EN
  logic clear = 1'b0;
  logic clear_busy;
`endif

  always #5 clk = ~clk;

  vga_frame_sink_if bus();

  vga_frame_sink #(.H_RES(16), .V_RES(4)) dut (
    .iClock(clk), .iReset(rst), .plot(bus),
`ifdef FB_CLEAR_EN
    .iClear(clear), .oClearBusy(clear_busy),
`endif
    .oVGA_R(r), .oVGA_G(g), .oVGA_B(b), .oVGA_HS(hs), .oVGA_VS(vs),
    .oVGA_BLANK_N(blank_n), .oVGA_CLK(vga_clk), .oFrameStart(fs)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] exp_q [$];
  logic [2:0] fb  [64];
  logic [2:0] fb2 [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    bus.iX = x; bus.iY = y; bus.iColour = c; bus.iPlot = 1'b1;
    @(posedge clk); #1;
    bus.iPlot = 1'b0;
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < FRAME_CLK + 2000; i++) begin
      @(posedge clk); #1;
      if (fs) begin ok = 1'b1; break; end
    end
  endtask

  task automatic push_frame(input bit second);
    for (int v = 0; v < 16; v++)
      for (int h = 0; h < 64; h++)
        exp_q.push_back(second ? fb2[(v / 4) * 16 + h / 4] : fb[(v / 4) * 16 + h / 4]);
  endtask

  // Pixel monitor: one sample per pixel clock, mid-way between output updates
  always @(posedge clk) begin
    logic [2:0] c;
    #1;
    if (!rst && vga_clk) begin
      if (blank_n) begin
        if (exp_q.size() > 0) begin
          c = exp_q.pop_front();
          check("pixel_rgb", {r, g, b}, {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}});
        end
      end else begin
        check("blank_rgb_zero", {r, g, b}, 24'd0);
      end
    end
  end

  // Sync timing monitor, cycle count starts at the first edge after reset release
  int cyc = 0, hs_fall = -1, vs_fall = -1, fs_last = -1, fs_cnt = 0;
  logic p_hs = 1'b1, p_vs = 1'b1, p_fs = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      cyc = 0; p_hs = 1'b1; p_vs = 1'b1; p_fs = 1'b0;
    end else begin
      cyc++;
      if (p_hs && !hs) begin
        if (hs_fall < 0) check("hs_first_low", cyc, HS_FIRST);
        else             check("hs_period", cyc - hs_fall, LINE_CLK);
        hs_fall = cyc;
      end
      if (!p_hs && hs) check("hs_low_width", cyc - hs_fall, 192);
      if (p_vs && !vs) begin
        if (vs_fall < 0) check("vs_first_low", cyc, VS_FIRST);
        else begin
          check("vs_period", cyc - vs_fall, FRAME_CLK);
          check("fs_per_frame", fs_cnt, 1);
        end
        fs_cnt  = 0;
        vs_fall = cyc;
      end
      if (!p_vs && vs) check("vs_low_width", cyc - vs_fall, 2 * LINE_CLK);
      if (fs) begin
        fs_cnt++;
        check("fs_one_cycle", p_fs, 1'b0);
        if (fs_last < 0) check("fs_first", cyc, FS_FIRST);
        else             check("fs_period", cyc - fs_last, FRAME_CLK);
        fs_last = cyc;
      end
      p_hs = hs; p_vs = vs; p_fs = fs;
    end
  end

  initial begin
    bit ok;
    int k;
    bus.iX = 8'd0; bus.iY = 7'd0; bus.iColour = 3'd0; bus.iPlot = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_hs", hs, 1'b1);
    check("rst_vs", vs, 1'b1);
    check("rst_blank_n", blank_n, 1'b0);
    check("rst_rgb", {r, g, b}, 24'd0);
    check("rst_vga_clk", vga_clk, 1'b0);
    check("rst_frame_start", fs, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    wait_fs(ok);
    check("frame0_start_seen", ok, 1'b1);
    for (int i = 0; i < 64; i++) fb[i] = 3'((i % 16 + 3 * (i / 16)) % 8);
    fb[0]  = 3'b100;
    fb[63] = 3'b011;
    k = 0;
    for (int i = 0; i < 64; i++) begin
      plot(8'(i % 16), 7'(i / 16), fb[i]);
      k++;
    end
    plot(8'd16, 7'd1, 3'b111);
    plot(8'd17, 7'd0, 3'b111);
    plot(8'd2, 7'd4, 3'b111);
    plot(8'd255, 7'd127, 3'b111);
    k += 4;

    for (int i = 0; i < 64; i++) begin
`ifdef FB_CLEAR_EN
      fb2[i] = 3'b000;
`else
      fb2[i] = fb[i];
`endif
    end
`ifndef FB_CLEAR_EN
    fb2[2 * 16 + 5] = 3'b110;
`endif
    push_frame(1'b0);
    push_frame(1'b1);

    repeat (SAME_ADDR_EDGE - k - 1) @(posedge clk);
    #1;
    plot(8'd5, 7'd2, 3'b110);

    wait_fs(ok);
    check("frame1_start_seen", ok, 1'b1);
`ifdef FB_CLEAR_EN
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    k = 0;
    while (clear_busy && k < 1000) begin
      k++;
      if (k == 10) begin
        bus.iX = 8'd3; bus.iY = 7'd0; bus.iColour = 3'b111; bus.iPlot = 1'b1;
      end else begin
        bus.iPlot = 1'b0;
      end
      clear = (k == 20);
      @(posedge clk); #1;
    end
    bus.iPlot = 1'b0;
    clear = 1'b0;
    check("clear_busy_cycles", k, 64);
`endif

    wait_fs(ok);
    check("frame2_start_seen", ok, 1'b1);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
